// File: rtl/subtractor_400bit_pkg.sv
// Shared constants, state encoding and index sizing for the byte-serial subtractor.
// Optional feature macro: SUB400_ABS_EN (magnitude result via a negate pass).
package subtractor_400bit_pkg;

    localparam int LIMBS_DEF = 50;
    localparam int W_DEF     = 8;

    // One spare bit so the index can reach LIMBS without wrapping back to limb 0.
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int IDX_W = idx_width(LIMBS_DEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_NEG,
        S_DONE
    } sub_state_t;

endpackage

// File: rtl/subtractor_400bit_limb_sub.sv
// Combinational W-bit subtract with borrow-in/borrow-out, shared by the SUB and NEG passes.
module limb_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         bin_i,
    output logic [W-1:0] d_o,
    output logic         bout_o
);

    logic [W:0] full;

    // The extra top bit of the (W+1)-bit difference is the borrow out.
    assign full   = {1'b0, x_i} - {1'b0, y_i} - {{W{1'b0}}, bin_i};
    assign d_o    = full[W-1:0];
    assign bout_o = full[W];

endmodule

// File: rtl/subtractor_400bit.sv
// Byte-serial multi-precision subtractor, LSB limb first, one limb per clock.
// Define SUB400_ABS_EN to turn a negative result into its magnitude with a second pass.
module subtractor_400bit
    import subtractor_400bit_pkg::*;
#(
    parameter int LIMBS = LIMBS_DEF,
    parameter int W     = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a      [LIMBS],
    input  logic [W-1:0] b      [LIMBS],
    output logic [W-1:0] diff   [LIMBS],
    output logic         borrow,
    output logic         neg,
    output logic         busy,
    output logic         done
);

    localparam int            IW   = idx_width(LIMBS);
    localparam int            AW   = IW - 1;
    localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);
    localparam logic [IW-1:0] ENDI = IW'(LIMBS);

    sub_state_t    state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          borrow_q;
    logic [W-1:0]  diff_q [LIMBS];

    logic [AW-1:0] addr;
    logic          last_limb;
    logic [W-1:0]  op_x, op_y, res;
    logic          op_bin, res_bout;

`ifdef SUB400_ABS_EN
    logic          neg_q;
    logic          nbr_q;
`endif

    assign last_limb = (idx_q == LAST);
    // Outside SUB/NEG the index may sit at LIMBS; clamp so no out-of-range limb is read.
    assign addr      = (idx_q < ENDI) ? idx_q[AW-1:0] : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op_x   = a[addr];
        op_y   = b[addr];
        op_bin = borrow_q;
`ifdef SUB400_ABS_EN
        if (state_q == S_NEG) begin
            op_x   = '0;
            op_y   = diff_q[addr];
            op_bin = nbr_q;
        end
`endif
    end

    limb_sub #(.W(W)) u_limb_sub (
        .x_i    (op_x),
        .y_i    (op_y),
        .bin_i  (op_bin),
        .d_o    (res),
        .bout_o (res_bout)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_SUB;
        end else begin
            case (state_q)
                S_SUB: begin
                    if (last_limb) begin
`ifdef SUB400_ABS_EN
                        state_d = res_bout ? S_NEG : S_DONE;
`else
                        state_d = S_DONE;
`endif
                    end
                end
                S_NEG: begin
                    if (last_limb) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_SUB) || (state_q == S_NEG);
        done = (state_q == S_DONE);
    end

    // NOTE: the result limbs are a register file that must read as zero after reset,
    // so each limb is cleared explicitly in the reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            borrow_q <= 1'b0;
            for (int i = 0; i < LIMBS; i++) begin
                diff_q[i] <= '0;
            end
`ifdef SUB400_ABS_EN
            neg_q    <= 1'b0;
            nbr_q    <= 1'b0;
`endif
        end else if (start) begin
            idx_q    <= '0;
            borrow_q <= 1'b0;
`ifdef SUB400_ABS_EN
            neg_q    <= 1'b0;
            nbr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_SUB: begin
                    diff_q[addr] <= res;
                    borrow_q     <= res_bout;
                    idx_q        <= idx_q + IW'(1);
`ifdef SUB400_ABS_EN
                    if (last_limb && res_bout) begin
                        idx_q <= '0;
                        neg_q <= 1'b1;
                        nbr_q <= 1'b0;
                    end
`endif
                end
`ifdef SUB400_ABS_EN
                S_NEG: begin
                    diff_q[addr] <= res;
                    nbr_q        <= res_bout;
                    idx_q        <= idx_q + IW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SUB400_ABS_EN
    assign neg    = neg_q;
`else
    assign neg    = 1'b0;
`endif

endmodule
